// File: rtl/board_input_conditioner.sv
// Multi-channel synchroniser, counter-based debounce filter and edge-event generator for board inputs.
// Define BOARD_INPUT_GLITCH_COUNT_EN to add the saturating glitch_count output.
module board_input_conditioner #(
  parameter int unsigned          CHANNELS        = 3,
  parameter int unsigned          SYNC_STAGES     = 2,
  parameter int unsigned          DEBOUNCE_CYCLES = 120000,
  parameter logic [CHANNELS-1:0]  INIT_LEVEL      = {CHANNELS{1'b0}}
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] stable_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_event
`ifdef BOARD_INPUT_GLITCH_COUNT_EN
  ,
  output logic [15:0]         glitch_count
`endif
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned GLITCH_W = 16;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("board_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("board_input_conditioner: SYNC_STAGES must be >= 2");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("board_input_conditioner: CHANNELS must be >= 1");
  end

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] sync_c;
  logic [CHANNELS-1:0] stable_d;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;
  logic [CHANNELS-1:0] glitch_c;
  logic                any_event_d;

  assign sync_c = sync_q[SYNC_STAGES-1];

  // Per-channel debounce state machine; the counter value is the state (0 = idle, >0 = qualifying).
  always_comb begin
    stable_d = stable_out;
    rise_d   = '0;
    fall_d   = '0;
    glitch_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_d[i] = '0;
      if (sync_c[i] != stable_out[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync_c[i];
          rise_d[i]   = sync_c[i];
          fall_d[i]   = ~sync_c[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (cnt_q[i] != '0) begin
        glitch_c[i] = 1'b1;
      end
    end
    any_event_d = |{rise_d, fall_d};
  end

  // Synchroniser chain, debounce counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= INIT_LEVEL;
      for (int i = 0; i < int'(CHANNELS); i++) cnt_q[i] <= '0;
      stable_out <= INIT_LEVEL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      any_event  <= 1'b0;
    end else begin
      sync_q[0] <= raw_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < int'(CHANNELS); i++) cnt_q[i] <= cnt_d[i];
      stable_out <= stable_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      any_event  <= any_event_d;
    end
  end

`ifdef BOARD_INPUT_GLITCH_COUNT_EN
  // Cycles with at least one aborted qualification, saturating.
  always_ff @(posedge clock) begin
    if (reset) begin
      glitch_count <= '0;
    end else if ((|glitch_c) && (glitch_count != {GLITCH_W{1'b1}})) begin
      glitch_count <= glitch_count + GLITCH_W'(1);
    end
  end
`else
  logic unused_glitch;
  assign unused_glitch = |glitch_c;
`endif

endmodule
